// File: rtl/nv_cfg_bits_mgr.sv
// Non-volatile config-bit manager: decodes host command bytes and sequences UFM write/read strobes.
// Optional post-write verify with retries is enabled by defining NVCFG_VERIFY_EN.
module nv_cfg_bits_mgr #(
   parameter int unsigned NBITS     = 4,
   parameter int unsigned CNT_W     = 11,
   parameter logic [3:0]  WR_OPC    = 4'h5,
   parameter logic [7:0]  RD_CMD    = 8'hB0,
   parameter int unsigned T_WR_ON   = 32,
   parameter int unsigned T_WR_OFF  = 1047,
   parameter int unsigned T_RB_ON   = 1063,
   parameter int unsigned T_RB_OFF  = 1079,
   parameter int unsigned T_WR_END  = 1095,
   parameter int unsigned T_RD_ON   = 32,
   parameter int unsigned T_RD_OFF  = 48,
   parameter int unsigned T_RD_END  = 100,
   parameter int unsigned MAX_RETRY = 2
) (
   input  logic             CLK32768,
   input  logic             ResetN,
   input  logic             Strobe1ms,
   input  logic [7:0]       SpecialCmdReg,
   input  logic             bPromBusy,
   input  logic [NBITS-1:0] CfgRdBits,
   output logic             bFlashPromReq,
   output logic             bWrPromCfg,
   output logic             bRdPromCfg,
   output logic [NBITS-1:0] CfgWrBits,
   output logic             CmdDone,
   output logic             CmdErr,
   output logic [2:0]       DbgP
);

   // Reject parameter sets the counter or index field cannot represent
   if (NBITS < 1 || NBITS > 8 || T_WR_END >= (32'd1 << CNT_W) || T_RD_END >= (32'd1 << CNT_W)
       || MAX_RETRY > 255) begin : g_bad_param
      $error("nv_cfg_bits_mgr: illegal parameter set");
   end

`ifdef NVCFG_VERIFY_EN
   localparam int unsigned RTRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2, VERIFY = 2'd3} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2} state_t;
`endif

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
   logic [7:0]       r_shadow, w_shadow_nxt;
   logic             r_req, w_req_nxt;
   logic             r_wr, w_wr_nxt;
   logic             r_rd, w_rd_nxt;
   logic [NBITS-1:0] r_bits, w_bits_nxt;
   logic             r_done, w_done_nxt;
   logic             r_err, w_err_nxt;
   logic [2:0]       w_idx;
   logic [NBITS-1:0] w_mask, w_new_bits;
   logic             w_is_wr, w_idx_ok;
`ifdef NVCFG_VERIFY_EN
   logic [RTRY_W-1:0] r_retry, w_retry_nxt;
   logic [NBITS-1:0]  w_vmask;
   logic              w_vok;
`endif

   // Command field decode and the bit image a write would store
   always_comb begin
      w_cnt_inc  = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);
      w_idx      = SpecialCmdReg[3:1];
      w_mask     = NBITS'(1) << w_idx;
      w_new_bits = SpecialCmdReg[0] ? (CfgRdBits | w_mask) : (CfgRdBits & ~w_mask);
      w_is_wr    = (SpecialCmdReg[7:4] == WR_OPC);
      w_idx_ok   = (32'(w_idx) < NBITS);
`ifdef NVCFG_VERIFY_EN
      w_vmask    = NBITS'(1) << r_shadow[3:1];
      w_vok      = (((CfgRdBits & w_vmask) != '0) == r_shadow[0]);
`endif
   end

   // Next-state and registered-output logic; everything advances on Strobe1ms only
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_shadow_nxt = r_shadow;
      w_req_nxt    = r_req;
      w_wr_nxt     = r_wr;
      w_rd_nxt     = r_rd;
      w_bits_nxt   = r_bits;
      w_done_nxt   = 1'b0;
      w_err_nxt    = 1'b0;
`ifdef NVCFG_VERIFY_EN
      w_retry_nxt  = r_retry;
`endif
      if (Strobe1ms) begin
         case (r_state)
            IDLE: begin
               w_req_nxt  = 1'b0;
               w_wr_nxt   = 1'b0;
               w_rd_nxt   = 1'b0;
               w_bits_nxt = CfgRdBits;
               // A busy controller leaves the command pending in SpecialCmdReg
               if (!bPromBusy && (SpecialCmdReg != r_shadow)) begin
                  if (SpecialCmdReg == RD_CMD) begin
                     w_state_nxt  = READ;
                     w_req_nxt    = 1'b1;
                     w_shadow_nxt = SpecialCmdReg;
                     w_cnt_nxt    = '0;
`ifdef NVCFG_VERIFY_EN
                     w_retry_nxt  = '0;
`endif
                  end else if (w_is_wr && w_idx_ok) begin
                     w_state_nxt  = WRITE;
                     w_req_nxt    = 1'b1;
                     w_bits_nxt   = w_new_bits;
                     w_shadow_nxt = SpecialCmdReg;
                     w_cnt_nxt    = '0;
`ifdef NVCFG_VERIFY_EN
                     w_retry_nxt  = '0;
`endif
                  end else if (w_is_wr) begin
                     w_err_nxt    = 1'b1;
                     w_shadow_nxt = SpecialCmdReg;
                     w_cnt_nxt    = '0;
                  end
               end
            end
            WRITE: begin
               w_cnt_nxt = w_cnt_inc;
               if (w_cnt_inc == CNT_W'(T_WR_ON))  w_wr_nxt = 1'b1;
               if (w_cnt_inc == CNT_W'(T_WR_OFF)) w_wr_nxt = 1'b0;
               if (w_cnt_inc == CNT_W'(T_RB_ON))  w_rd_nxt = 1'b1;
               if (w_cnt_inc == CNT_W'(T_RB_OFF)) w_rd_nxt = 1'b0;
               if (w_cnt_inc >= CNT_W'(T_WR_END)) begin
                  w_wr_nxt = 1'b0;
                  w_rd_nxt = 1'b0;
`ifdef NVCFG_VERIFY_EN
                  w_state_nxt = VERIFY;
`else
                  w_state_nxt = IDLE;
                  w_req_nxt   = 1'b0;
                  w_done_nxt  = 1'b1;
`endif
               end
            end
            READ: begin
               w_cnt_nxt = w_cnt_inc;
               if (w_cnt_inc == CNT_W'(T_RD_ON))  w_rd_nxt = 1'b1;
               if (w_cnt_inc == CNT_W'(T_RD_OFF)) w_rd_nxt = 1'b0;
               if (w_cnt_inc >= CNT_W'(T_RD_END)) begin
                  w_state_nxt = IDLE;
                  w_req_nxt   = 1'b0;
                  w_wr_nxt    = 1'b0;
                  w_rd_nxt    = 1'b0;
                  w_done_nxt  = 1'b1;
               end
            end
`ifdef NVCFG_VERIFY_EN
            VERIFY: begin
               if (w_vok) begin
                  w_state_nxt = IDLE;
                  w_req_nxt   = 1'b0;
                  w_done_nxt  = 1'b1;
               end else if (r_retry < RTRY_W'(MAX_RETRY)) begin
                  w_state_nxt = WRITE;
                  w_retry_nxt = r_retry + RTRY_W'(1);
                  w_cnt_nxt   = '0;
               end else begin
                  w_state_nxt = IDLE;
                  w_req_nxt   = 1'b0;
                  w_err_nxt   = 1'b1;
               end
            end
`endif
            default: begin
               w_state_nxt = IDLE;
               w_req_nxt   = 1'b0;
               w_wr_nxt    = 1'b0;
               w_rd_nxt    = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK32768 or negedge ResetN) begin
      if (!ResetN) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_shadow <= 8'h00;
         r_req    <= 1'b0;
         r_wr     <= 1'b0;
         r_rd     <= 1'b0;
         r_bits   <= '0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
`ifdef NVCFG_VERIFY_EN
         r_retry  <= '0;
`endif
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_shadow <= w_shadow_nxt;
         r_req    <= w_req_nxt;
         r_wr     <= w_wr_nxt;
         r_rd     <= w_rd_nxt;
         r_bits   <= w_bits_nxt;
         r_done   <= w_done_nxt;
         r_err    <= w_err_nxt;
`ifdef NVCFG_VERIFY_EN
         r_retry  <= w_retry_nxt;
`endif
      end
   end

   assign bFlashPromReq = r_req;
   assign bWrPromCfg    = r_wr;
   assign bRdPromCfg    = r_rd;
   assign CfgWrBits     = r_bits;
   assign CmdDone       = r_done;
   assign CmdErr        = r_err;
   assign DbgP          = 3'(r_state);

endmodule
